threshold_table_loader: RTL and testbench

Sequential writer that fills the comparator's threshold RAM through its BRAM write port. On a start pulse it walks every count address 0..VECTOR_WIDTH and writes one saturated fixed-point threshold entry per cycle, computed incrementally as entry(c) = min(floor(c·COEF / 2^FRAC_BITS), 2^CNT_WIDTH−1). It sits between the host configuration path and the comparator, and holds off the fingerprint stream via o_Busy while the table is being rewritten.

---
 rtl/threshold_table_loader_pkg.sv | 27 ++
 rtl/threshold_table_loader.sv | 124 ++++++++++++
 tb/tb_threshold_table_loader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_table_loader_pkg.sv
// Shared constants, width derivation and state encoding for the threshold table loader.
package threshold_table_loader_pkg;

  localparam int unsigned VECTOR_WIDTH_DEF = 920;
  localparam int unsigned COEF_WIDTH_DEF   = 16;
  localparam int unsigned FRAC_BITS_DEF    = 12;

  // Same width rule the comparator uses for its count/threshold words.
  function automatic int unsigned cnt_width(input int unsigned vw);
    return $clog2(vw);
  endfunction

  // Largest entry value representable in a cw-bit threshold word.
  function automatic int unsigned sat_max(input int unsigned cw);
    return (32'(1) << cw) - 32'(1);
  endfunction

  localparam int unsigned CNT_WIDTH_DEF = cnt_width(VECTOR_WIDTH_DEF);
  localparam int unsigned SAT_MAX_DEF   = sat_max(CNT_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/threshold_table_loader.sv
// Walks count addresses 0..VECTOR_WIDTH and writes saturated fixed-point thresholds
// into the comparator RAM, one per cycle, holding off the fingerprint stream via o_Busy.
module threshold_table_loader
  import threshold_table_loader_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int unsigned COEF_WIDTH   = COEF_WIDTH_DEF,
  parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF,
  parameter int unsigned CNT_WIDTH    = cnt_width(VECTOR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_Start,
  input  logic [COEF_WIDTH-1:0] i_Coef,
  input  logic                  i_Hold,
  output logic [CNT_WIDTH-1:0]  o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]  o_BRAM_Din,
  output logic                  o_BRAM_En,
  output logic                  o_BRAM_WrEn,
  output logic                  o_Busy,
  output logic                  o_Done
);

  // Address counter carries one extra bit so it can reach VECTOR_WIDTH+1.
  localparam int unsigned ADR_W   = CNT_WIDTH + 1;
  localparam int unsigned ACC_W   = CNT_WIDTH + COEF_WIDTH;
  localparam int unsigned SAT_MAX = sat_max(CNT_WIDTH);

  state_t                state, state_nx;
  logic [ADR_W-1:0]      c, c_nx, src_c;
  logic [ACC_W-1:0]      acc, acc_nx, src_acc, quo;
  logic [COEF_WIDTH-1:0] coef, coef_nx, src_coef;
  logic [CNT_WIDTH-1:0]  addr_nx, din_nx;
  logic                  en_nx, busy_nx, done_nx, step;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      c           <= '0;
      acc         <= '0;
      coef        <= '0;
      o_BRAM_Addr <= '0;
      o_BRAM_Din  <= '0;
      o_BRAM_En   <= 1'b0;
      o_BRAM_WrEn <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      state       <= state_nx;
      c           <= c_nx;
      acc         <= acc_nx;
      coef        <= coef_nx;
      o_BRAM_Addr <= addr_nx;
      o_BRAM_Din  <= din_nx;
      o_BRAM_En   <= en_nx;
      o_BRAM_WrEn <= en_nx;
      o_Busy      <= busy_nx;
      o_Done      <= done_nx;
    end
  end

  // Outputs are decided one edge ahead so a write is visible the cycle after acceptance.
  always_comb begin
    state_nx = state;
    c_nx     = c;
    acc_nx   = acc;
    coef_nx  = coef;
    addr_nx  = o_BRAM_Addr;
    din_nx   = o_BRAM_Din;
    en_nx    = 1'b0;
    busy_nx  = o_Busy;
    done_nx  = 1'b0;
    src_c    = c;
    src_acc  = acc;
    src_coef = coef;
    step     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_Start) begin
          state_nx = ST_WRITE;
          coef_nx  = i_Coef;
          src_c    = '0;
          src_acc  = '0;
          src_coef = i_Coef;
          busy_nx  = 1'b1;
          step     = 1'b1;
        end
      end
      ST_WRITE: begin
        if (c == ADR_W'(VECTOR_WIDTH + 1)) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
          addr_nx  = '0;
          din_nx   = '0;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = ST_IDLE;
    endcase

    quo = src_acc >> FRAC_BITS;

    // A held cycle leaves counter, accumulator and the last Addr/Din untouched.
    if (step) begin
      if (!i_Hold) begin
        addr_nx = CNT_WIDTH'(src_c);
        din_nx  = (quo > ACC_W'(SAT_MAX)) ? CNT_WIDTH'(SAT_MAX) : CNT_WIDTH'(quo);
        en_nx   = 1'b1;
        c_nx    = src_c + ADR_W'(1);
        acc_nx  = src_acc + ACC_W'(src_coef);
      end else begin
        c_nx   = src_c;
        acc_nx = src_acc;
      end
    end
  end

endmodule

// File: tb/tb_threshold_table_loader.sv
// Self-checking bench for threshold_table_loader: captured writes are compared
// against min(floor(c*coef/4096), 1023) together with load timing and control behaviour.
module tb_threshold_table_loader;

  localparam int NENT = 921;
  localparam int SATV = 1023;

  logic        clk = 1'b0;
  logic        rstn, i_Start, i_Hold;
  logic [15:0] i_Coef;
  logic [9:0]  addr, din;
  logic        en, wren, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int busy_cnt, done_cnt, done_rel, wren_bad;
  int cap_addr[$];
  int cap_din[$];
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  threshold_table_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_Start     (i_Start),
    .i_Coef      (i_Coef),
    .i_Hold      (i_Hold),
    .o_BRAM_Addr (addr),
    .o_BRAM_Din  (din),
    .o_BRAM_En   (en),
    .o_BRAM_WrEn (wren),
    .o_Busy      (busy),
    .o_Done      (done)
  );

  always @(posedge clk) cyc++;

  // Write and control observer, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (en === 1'b1) begin
        cap_addr.push_back(int'(addr));
        cap_din.push_back(int'(din));
      end
      if (en !== wren) wren_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_rel = cyc - s_cyc + 1;
      end
    end
  end

  function automatic int model(input int c, input int coef);
    longint p;
    p = (longint'(c) * longint'(coef)) / 4096;
    return (p > SATV) ? SATV : int'(p);
  endfunction

  // Number of captured writes that disagree with the reference table.
  function automatic int table_bad(input int coef);
    int bad;
    bad = 0;
    if (cap_addr.size() != NENT) bad++;
    for (int i = 0; i < cap_addr.size(); i++)
      if (cap_addr[i] != i || cap_din[i] != model(i, coef)) bad++;
    return bad;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_load(input int coef, input bit hold);
    tick();
    cap_addr.delete();
    cap_din.delete();
    busy_cnt = 0;
    done_cnt = 0;
    done_rel = -1;
    wren_bad = 0;
    s_cyc    = cyc + 1;
    mon_on   = 1'b1;
    i_Start  = 1'b1;
    i_Coef   = 16'(coef);
    i_Hold   = hold;
    tick();
    i_Start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: o_Done never seen, got busy=%b required done=1", name, busy);
    end
  endtask

  task automatic wait_addr(input int a, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (en === 1'b1 && int'(addr) == a) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_reach: address %0d never written, got addr=%0d", name, a, addr);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_Start = 1'b0; i_Hold = 1'b0; i_Coef = '0;
    tick(); tick();
    checks++;
    if ({addr, din, en, wren, busy, done} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d din=%0d en=%b wren=%b busy=%b done=%b required all 0",
               addr, din, en, wren, busy, done);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_unity();
    int bad;
    start_load(4096, 1'b0);
    wait_done("unity");
    bad = table_bad(4096);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL unity_table: got %0d bad entries of %0d writes required 0 of %0d", bad, cap_addr.size(), NENT); end
    checks++;
    if (done_rel !== 922) begin errors++; $display("FAIL unity_done_cycle: got start+%0d required start+922", done_rel); end
    checks++;
    if (busy_cnt !== 922) begin errors++; $display("FAIL unity_busy_len: got %0d required 922", busy_cnt); end
    checks++;
    if (wren_bad !== 0) begin errors++; $display("FAIL unity_wren_eq_en: got %0d differing cycles required 0", wren_bad); end
  endtask

  task automatic test_back_to_back();
    int bad;
    start_load(6144, 1'b0);
    checks++;
    if (en !== 1'b1 || addr !== 10'd0 || din !== 10'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_write: got en=%b addr=%0d din=%0d busy=%b required 1 0 0 1", en, addr, din, busy);
    end
    wait_done("b2b");
    checks++;
    if (cap_din.size() < 6 || cap_din[3] !== 4 || cap_din[5] !== 7) begin
      errors++;
      $display("FAIL floor_entries: got size=%0d e3=%0d e5=%0d required e3=4 e5=7",
               cap_din.size(), cap_din.size() > 3 ? cap_din[3] : -1, cap_din.size() > 5 ? cap_din[5] : -1);
    end
    bad = table_bad(6144);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_table: got %0d bad entries required 0", bad); end
    checks++;
    if (done_rel !== 922) begin errors++; $display("FAIL b2b_done_cycle: got start+%0d required start+922", done_rel); end
  endtask

  task automatic test_saturation();
    int bad, nsat;
    start_load(10240, 1'b0);
    wait_done("sat");
    checks++;
    if (cap_din.size() != NENT || cap_din[409] !== 1022 || cap_din[410] !== 1023) begin
      errors++;
      $display("FAIL sat_knee: got size=%0d e409=%0d e410=%0d required 1022 1023",
               cap_din.size(), cap_din.size() > 409 ? cap_din[409] : -1, cap_din.size() > 410 ? cap_din[410] : -1);
    end
    nsat = 0;
    for (int i = 410; i < cap_din.size(); i++) if (cap_din[i] == SATV) nsat++;
    checks++;
    if (nsat !== NENT - 410) begin errors++; $display("FAIL sat_tail: got %0d saturated entries required %0d", nsat, NENT - 410); end
    bad = table_bad(10240);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sat_table: got %0d bad entries required 0", bad); end
  endtask

  task automatic test_zero();
    int nz;
    start_load(0, 1'b0);
    wait_done("zero");
    nz = 0;
    foreach (cap_din[i]) if (cap_din[i] == 0) nz++;
    checks++;
    if (nz !== NENT || cap_din.size() !== NENT) begin
      errors++;
      $display("FAIL zero_table: got %0d zero entries of %0d writes required %0d", nz, cap_din.size(), NENT);
    end
  endtask

  task automatic test_hold();
    int hbad, bad;
    start_load(4096, 1'b0);
    wait_addr(100, "hold");
    i_Hold = 1'b1;
    hbad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (en !== 1'b0 || addr !== 10'd100) hbad++;
    end
    i_Hold = 1'b0;
    tick();
    checks++;
    if (hbad !== 0) begin errors++; $display("FAIL hold_freeze: got %0d bad hold cycles required 0", hbad); end
    checks++;
    if (en !== 1'b1 || addr !== 10'd101) begin errors++; $display("FAIL hold_resume: got en=%b addr=%0d required 1 101", en, addr); end
    wait_done("hold");
    bad = table_bad(4096);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_table: got %0d bad entries required 0", bad); end
    checks++;
    if (done_rel !== 925) begin errors++; $display("FAIL hold_done_cycle: got start+%0d required start+925", done_rel); end
  endtask

  task automatic test_start_ignored();
    int bad;
    start_load(8192, 1'b0);
    wait_addr(300, "ign");
    i_Start = 1'b1;
    i_Coef  = 16'd4096;
    tick();
    i_Start = 1'b0;
    wait_done("ign");
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    checks++;
    if (busy !== 1'b0 || en !== 1'b0) begin errors++; $display("FAIL ign_after_done: got busy=%b en=%b required 0 0", busy, en); end
    tick();
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL ign_single_done: got busy=%b done_count=%0d required 0 1", busy, done_cnt); end
    bad = table_bad(8192);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ign_table: got %0d bad entries required 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    start_load(4096, 1'b0);
    wait_addr(500, "rst");
    rstn = 1'b0;
    tick();
    checks++;
    if ({addr, din, en, wren, busy, done} !== 24'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got addr=%0d din=%0d en=%b wren=%b busy=%b done=%b required all 0",
               addr, din, en, wren, busy, done);
    end
    rstn = 1'b1;
    tick(); tick();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got done_count=%0d busy=%b required 0 0", done_cnt, busy); end
    start_load(4096, 1'b0);
    wait_done("rst_reload");
    bad = table_bad(4096);
    checks++;
    if (bad !== 0 || done_rel !== 922) begin
      errors++;
      $display("FAIL rst_reload: got %0d bad entries done at start+%0d required 0 and start+922", bad, done_rel);
    end
  endtask

  task automatic test_random();
    int coef, holds, bad;
    bit h;
    for (int it = 0; it < 3; it++) begin
      coef = int'($urandom_range(0, 65535));
      h = (it == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      holds = int'(h);
      start_load(coef, h);
      if (it == 0) begin
        checks++;
        if (en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rand_start_hold: got en=%b busy=%b required 0 1", en, busy); end
      end
      for (int n = 0; n < 3000; n++) begin
        h = (cap_addr.size() < 900) && ($urandom_range(0, 3) == 0);
        i_Hold = h;
        holds += int'(h);
        tick();
        if (done === 1'b1) break;
      end
      i_Hold = 1'b0;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL rand_timeout: coef=%0d got done=%b required 1", coef, done); end
      bad = table_bad(coef);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rand_table: coef=%0d got %0d bad entries required 0", coef, bad); end
      checks++;
      if (done_rel !== 922 + holds) begin
        errors++;
        $display("FAIL rand_done_cycle: coef=%0d got start+%0d required start+%0d", coef, done_rel, 922 + holds);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_back_to_back();
    test_saturation();
    test_zero();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
